cla_operand_stage: RTL and testbench

//  Upstream issue/capture stage for the 32-bit CLA adder. Buffers operand pairs from a

---
 rtl/cla_pkg.sv | 21 ++
 rtl/cla_operand_fifo.sv | 71 +++++++
 rtl/cla_operand_stage.sv | 185 ++++++++++++++++++
 tb/tb_cla_operand_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA operand issue/capture stage: default widths,
// settle-counter bound, FSM state encoding and the signed-overflow helper.
package cla_pkg;

  localparam int CLA_WIDTH      = 32;
  localparam int CLA_SETTLE_MAX = 15;
  localparam int CLA_CNT_W      = $clog2(CLA_SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cla_state_e;

  // Two's-complement overflow of a+b: operands share a sign the sum does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_operand_fifo.sv
// Two-entry operand FIFO for the CLA operand stage. Holds {a, b, cin} words.
// A push into a full FIFO is dropped even if a pop happens the same cycle;
// otherwise simultaneous push and pop are both honoured. Pointers wrap mod 2
// and a separate count register tracks occupancy 0..2.
module cla_operand_fifo #(
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          push_en_s;
  logic          pop_en_s;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cla_operand_stage.sv
// Issue/capture stage wrapped around an external combinational CLA adder.
// Operand pairs are buffered in a 2-entry FIFO, driven onto the adder from
// registers, allowed SETTLE_CYC cycles to propagate, then the sum and carry
// are captured and offered downstream on a valid/ready handshake.
// Optional feature: define CLA_OVF_FLAG_EN to add the out_ovf signed-overflow
// output, captured alongside out_sum.
module cla_operand_stage
  import cla_pkg::*;
#(
  parameter int WIDTH      = CLA_WIDTH,
  parameter int SETTLE_CYC = 2          // legal 1..CLA_SETTLE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int DW = 2 * WIDTH + 1;
  localparam logic [CLA_CNT_W-1:0] CNT_LOAD = CLA_CNT_W'(SETTLE_CYC - 1);

  cla_state_e           state_q, state_d;
  logic [CLA_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     add_a_q, add_a_d;
  logic [WIDTH-1:0]     add_b_q, add_b_d;
  logic                 add_cin_q, add_cin_d;
  logic [WIDTH-1:0]     out_sum_q, out_sum_d;
  logic                 out_cout_q, out_cout_d;
  logic                 out_valid_q, out_valid_d;
  logic                 rdy_en_q, rdy_en_d;
`ifdef CLA_OVF_FLAG_EN
  logic                 out_ovf_q, out_ovf_d;
`endif

  logic                 push_s;
  logic                 pop_s;
  logic [DW-1:0]        pop_data_s;
  logic                 full_s;
  logic                 empty_s;

  // rdy_en_q keeps in_ready low while reset is asserted and for the release
  // edge itself; the FIFO count alone would already read "not full" then.
  assign in_ready  = rdy_en_q && !full_s;
  assign push_s    = in_valid && in_ready;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = !empty_s || (state_q != IDLE);
`ifdef CLA_OVF_FLAG_EN
  assign out_ovf   = out_ovf_q;
`endif

  cla_operand_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({in_a, in_b, in_cin}),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Issue/settle/hold sequencing: pops operands, times the settle window and
  // captures the adder result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
    rdy_en_d    = 1'b1;
    pop_s       = 1'b0;
`ifdef CLA_OVF_FLAG_EN
    out_ovf_d   = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          add_a_d   = pop_data_s[DW-1 -: WIDTH];
          add_b_d   = pop_data_s[WIDTH -: WIDTH];
          add_cin_d = pop_data_s[0];
          cnt_d     = CNT_LOAD;
          state_d   = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == {CLA_CNT_W{1'b0}}) begin
          out_sum_d   = add_s;
          out_cout_d  = add_cout;
          out_valid_d = 1'b1;
`ifdef CLA_OVF_FLAG_EN
          out_ovf_d   = signed_ovf(add_a_q[WIDTH-1], add_b_q[WIDTH-1],
                                   add_s[WIDTH-1]);
`endif
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - {{(CLA_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          // Back-to-back issue: next operand goes straight into SETTLE.
          if (!empty_s) begin
            pop_s     = 1'b1;
            add_a_d   = pop_data_s[DW-1 -: WIDTH];
            add_b_d   = pop_data_s[WIDTH -: WIDTH];
            add_cin_d = pop_data_s[0];
            cnt_d     = CNT_LOAD;
            state_d   = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Stage registers; synchronous active-low reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CLA_CNT_W{1'b0}};
      add_a_q     <= {WIDTH{1'b0}};
      add_b_q     <= {WIDTH{1'b0}};
      add_cin_q   <= 1'b0;
      out_sum_q   <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      rdy_en_q    <= rdy_en_d;
`ifdef CLA_OVF_FLAG_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_cla_operand_stage.sv
// Self-checking bench for cla_operand_stage (SETTLE_CYC=2) wrapped around a
// behavioural 32-bit adder. Accepted operands go into a scoreboard queue;
// results are popped and compared when the output handshake happens.
// Define CLA_OVF_FLAG_EN to also exercise out_ovf.
module tb_cla_operand_stage;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef CLA_OVF_FLAG_EN
  logic         out_ovf;
`endif

  int           errors = 0;
  int           checks = 0;
  exp_t         sb[$];
  logic [W-1:0] res_sum[$];
  time          res_t[$];
  logic [W-1:0] bp_exp [3] = '{32'd4, 32'd8, 32'd12};

  always #5 clk = ~clk;

  // Environment adder standing in for the CLA.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  cla_operand_stage #(
    .WIDTH      (W),
    .SETTLE_CYC (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef CLA_OVF_FLAG_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop/compare on output handshake.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sum", {32'd0, out_sum}, {32'd0, e.sum});
          chk("sb_cout", {63'd0, out_cout}, {63'd0, e.cout});
`ifdef CLA_OVF_FLAG_EN
          chk("sb_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
`endif
        end
        res_sum.push_back(out_sum);
        res_t.push_back($time);
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_t     e;
        logic [W:0] full_sum;
        full_sum = {1'b0, in_a} + {1'b0, in_b} + {32'd0, in_cin};
        e.sum  = full_sum[W-1:0];
        e.cout = full_sum[W];
        e.ovf  = (in_a[W-1] == in_b[W-1]) && (full_sum[W-1] != in_a[W-1]);
        sb.push_back(e);
      end
    end
  end

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", {63'd0, n < 20}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {63'd0, n < max}, 64'd1);
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with in_valid asserted ----
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h0000_0005;
    in_b      = 32'h0000_0006;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_add_a", {32'd0, add_a}, 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdy_before_release_edge", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("rdy_after_release", {63'd0, in_ready}, 64'd1);
    chk("busy_after_release", {63'd0, busy}, 64'd0);
    chk("valid_after_release", {63'd0, out_valid}, 64'd0);

    // ---- single op: latency and wrap ----
    @(posedge clk);
    #1;
    push_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_on", {63'd0, out_valid}, 64'd1);
    chk("single_sum", {32'd0, out_sum}, 64'h0);
    chk("single_cout", {63'd0, out_cout}, 64'd1);
    chk("single_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("single_idle", {63'd0, busy}, 64'd0);
    chk("add_a_held", {32'd0, add_a}, 64'hFFFF_FFFF);

    // ---- backpressure: fill FIFO, then drain in order ----
    @(posedge clk);
    #1;
    res_sum.delete();
    push_op(32'd1, 32'd2, 1'b1);
    push_op(32'd3, 32'd4, 1'b1);
    push_op(32'd5, 32'd6, 1'b1);
    @(negedge clk);
    chk("bp_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 32'd99;
    in_b     = 32'd1;
    in_cin   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_hold_sum", {32'd0, out_sum}, 64'd4);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp_drain_timeout", 40);
    out_ready = 1'b0;
    chk("bp_count", 64'(res_sum.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_order", {32'd0, (i < res_sum.size()) ? res_sum[i] : 32'hFFFF_FFFF},
          {32'd0, bp_exp[i]});
    end

    // ---- streaming: one result every 3 cycles ----
    res_sum.delete();
    res_t.delete();
    out_ready = 1'b1;
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    push_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    wait_idle("st_drain_timeout", 60);
    chk("st_count", 64'(res_t.size()), 64'd5);
    for (int i = 1; i < 5; i++) begin
      chk("st_spacing", (i < res_t.size()) ? 64'(res_t[i] - res_t[i-1]) : 64'd0, 64'd30);
    end

    // ---- reset mid-operation with two ops queued ----
    out_ready = 1'b0;
    res_sum.delete();
    push_op(32'd10, 32'd20, 1'b0);
    push_op(32'd30, 32'd40, 1'b0);
    push_op(32'd50, 32'd60, 1'b0);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_busy_clear", {63'd0, busy}, 64'd0);
    end
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_no_result", 64'(res_sum.size()), 64'd0);

`ifdef CLA_OVF_FLAG_EN
    // ---- signed overflow flag ----
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovf_valid", {63'd0, out_valid}, 64'd1);
    chk("ovf_set", {63'd0, out_ovf}, 64'd1);
    chk("ovf_sum", {32'd0, out_sum}, 64'h8000_0000);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("ovf1_timeout", 20);
    out_ready = 1'b0;
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovf2_valid", {63'd0, out_valid}, 64'd1);
    chk("ovf2_clear", {63'd0, out_ovf}, 64'd0);
    chk("ovf2_cout", {63'd0, out_cout}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("ovf2_timeout", 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
